// File: rtl/uc_pkg.sv
// rtl/uc_pkg.sv - shared types and constants for the multicycle control unit.
package uc_pkg;

    localparam logic [7:0] TIMEOUT_CICLOS = 8'd255;
    localparam logic [2:0] R_LINK         = 3'd7;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_ALU   = 4'd1,
        OP_LDI   = 4'd2,
        OP_LOAD  = 4'd3,
        OP_STORE = 4'd4,
        OP_JUMP  = 4'd5,
        OP_JAL   = 4'd6,
        OP_BEQZ  = 4'd7,
        OP_HALT  = 4'd8
    } opcode_t;

    typedef enum logic [3:0] {
        CL_NOP, CL_ALU, CL_LDI, CL_LOAD, CL_STORE,
        CL_JUMP, CL_JAL, CL_BEQZ, CL_HALT, CL_ILEGAL
    } classe_t;

    typedef enum logic [2:0] {
        ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT, ST_ERRO
    } estado_t;

    localparam logic [1:0] MUX_ULA = 2'd0;
    localparam logic [1:0] MUX_MD  = 2'd1;
    localparam logic [1:0] MUX_PC  = 2'd2;

    localparam logic [2:0] EXT_NENHUM = 3'd0;
    localparam logic [2:0] EXT_SEXT9  = 3'd1;
    localparam logic [2:0] EXT_SEXT12 = 3'd2;

endpackage

// File: rtl/uc_decodificador.sv
// rtl/uc_decodificador.sv - combinational opcode decode into class, ALU function and extender mode.
module uc_decodificador
    import uc_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic [2:0] func,
    output classe_t    classe,
    output logic [2:0] ula_op,
    output logic [2:0] ext_modo
);

    always_comb begin
        classe   = CL_ILEGAL;
        ula_op   = 3'd0;
        ext_modo = EXT_NENHUM;
        case (opcode)
            OP_NOP:   classe = CL_NOP;
            OP_ALU: begin
                classe = CL_ALU;
                ula_op = func;
            end
            OP_LDI: begin
                classe   = CL_LDI;
                ext_modo = EXT_SEXT9;
            end
            OP_LOAD:  classe = CL_LOAD;
            OP_STORE: classe = CL_STORE;
            OP_JUMP: begin
                classe   = CL_JUMP;
                ext_modo = EXT_SEXT12;
            end
            OP_JAL: begin
                classe   = CL_JAL;
                ext_modo = EXT_SEXT12;
            end
            OP_BEQZ: begin
                classe   = CL_BEQZ;
                ext_modo = EXT_SEXT9;
            end
            OP_HALT:  classe = CL_HALT;
            default:  classe = CL_ILEGAL;
        endcase
    end

endmodule

// File: rtl/unidade_controle.sv
// rtl/unidade_controle.sv - multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit processor.
// Optional memory-wait timeout enabled by defining UC_MEM_TIMEOUT_EN.
module unidade_controle
    import uc_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        imem_ack,
    input  logic [15:0] instr,
    input  logic        dmem_ack,
    input  logic        a_zero,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        BR_Hab_Escrita,
    output logic [2:0]  BR_Sel_E_SA,
    output logic [2:0]  BR_Sel_SB,
    output logic [2:0]  EXcontrole,
    output logic [11:0] EXconstante,
    output logic [1:0]  controleMuxResu,
    output logic        controlePCcopia,
    output logic [2:0]  ula_op,
    output logic        pc_escreve,
    output logic        pc_sel,
    output logic        halted,
    output logic        erro
);

    estado_t     estado, prox;
    logic [15:0] ir;
    logic        ativo;
    logic        req_busca;
    logic        em_instr;
    logic        timeout;
    classe_t     classe;
    logic [2:0]  ula_dec;
    logic [2:0]  ext_modo;

    uc_decodificador u_dec (
        .opcode   (ir[15:12]),
        .func     (ir[2:0]),
        .classe   (classe),
        .ula_op   (ula_dec),
        .ext_modo (ext_modo)
    );

    // ativo keeps the fetch request low during reset and for the first cycle after release
    assign req_busca = (estado == ST_FETCH) && ativo;
    assign em_instr  = (estado == ST_DECODE) || (estado == ST_EXEC) ||
                       (estado == ST_MEM) || (estado == ST_WB);

`ifdef UC_MEM_TIMEOUT_EN
    logic [7:0] espera;
    logic       esperando;

    assign esperando = (req_busca && !imem_ack) || ((estado == ST_MEM) && !dmem_ack);
    assign timeout   = esperando && (espera == TIMEOUT_CICLOS - 8'd1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            espera <= 8'd0;
        end else if (esperando && !timeout) begin
            espera <= espera + 8'd1;
        end else begin
            espera <= 8'd0;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= ST_FETCH;
            ir     <= 16'd0;
            ativo  <= 1'b0;
        end else begin
            estado <= prox;
            ativo  <= 1'b1;
            if (req_busca && imem_ack) begin
                ir <= instr;
            end
        end
    end

    always_comb begin
        prox = estado;
        case (estado)
            ST_FETCH: begin
                if (timeout)                     prox = ST_ERRO;
                else if (req_busca && imem_ack)  prox = ST_DECODE;
            end
            ST_DECODE: begin
                if (classe == CL_ILEGAL)         prox = ST_ERRO;
                else if (classe == CL_HALT)      prox = ST_HALT;
                else                             prox = ST_EXEC;
            end
            ST_EXEC: begin
                case (classe)
                    CL_ALU, CL_LDI, CL_JAL: prox = ST_WB;
                    CL_LOAD, CL_STORE:      prox = ST_MEM;
                    default:                prox = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (timeout)                     prox = ST_ERRO;
                else if (dmem_ack)               prox = (classe == CL_LOAD) ? ST_WB : ST_FETCH;
            end
            ST_WB:                               prox = ST_FETCH;
            ST_HALT:                             prox = ST_HALT;
            ST_ERRO:                             prox = ST_ERRO;
            default:                             prox = ST_ERRO;
        endcase
    end

    always_comb begin
        imem_req        = req_busca;
        dmem_req        = 1'b0;
        dmem_we         = 1'b0;
        BR_Hab_Escrita  = 1'b0;
        BR_Sel_E_SA     = 3'd0;
        BR_Sel_SB       = 3'd0;
        EXcontrole      = EXT_NENHUM;
        EXconstante     = ir[11:0];
        controleMuxResu = MUX_ULA;
        controlePCcopia = 1'b0;
        ula_op          = 3'd0;
        pc_escreve      = 1'b0;
        pc_sel          = 1'b0;
        halted          = (estado == ST_HALT);
        erro            = (estado == ST_ERRO);

        // JAL targets the link register for the whole instruction so selects never move mid-flight
        if (em_instr) begin
            BR_Sel_E_SA = (classe == CL_JAL) ? R_LINK : ir[11:9];
            BR_Sel_SB   = ir[8:6];
            EXcontrole  = ext_modo;
            ula_op      = ula_dec;
            if (classe == CL_LOAD)     controleMuxResu = MUX_MD;
            else if (classe == CL_JAL) controleMuxResu = MUX_PC;
        end

        case (estado)
            ST_EXEC: begin
                case (classe)
                    CL_JUMP: begin
                        pc_escreve = 1'b1;
                        pc_sel     = 1'b1;
                    end
                    CL_BEQZ: begin
                        pc_escreve = 1'b1;
                        pc_sel     = a_zero;
                    end
                    CL_NOP:  pc_escreve      = 1'b1;
                    CL_JAL:  controlePCcopia = 1'b1;
                    default: ;
                endcase
            end
            ST_MEM: begin
                dmem_req   = 1'b1;
                dmem_we    = (classe == CL_STORE);
                pc_escreve = dmem_ack && (classe == CL_STORE);
            end
            ST_WB: begin
                BR_Hab_Escrita = 1'b1;
                pc_escreve     = 1'b1;
                pc_sel         = (classe == CL_JAL);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_unidade_controle.sv
// tb/tb_unidade_controle.sv - directed self-checking bench for unidade_controle.
module tb_unidade_controle;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        imem_ack = 1'b0;
    logic [15:0] instr = 16'd0;
    logic        dmem_ack = 1'b0;
    logic        a_zero = 1'b0;
    logic        imem_req, dmem_req, dmem_we, BR_Hab_Escrita;
    logic [2:0]  BR_Sel_E_SA, BR_Sel_SB, EXcontrole, ula_op;
    logic [11:0] EXconstante;
    logic [1:0]  controleMuxResu;
    logic        controlePCcopia, pc_escreve, pc_sel, halted, erro;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    unidade_controle dut (
        .clock           (clock),
        .reset           (reset),
        .imem_ack        (imem_ack),
        .instr           (instr),
        .dmem_ack        (dmem_ack),
        .a_zero          (a_zero),
        .imem_req        (imem_req),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .BR_Hab_Escrita  (BR_Hab_Escrita),
        .BR_Sel_E_SA     (BR_Sel_E_SA),
        .BR_Sel_SB       (BR_Sel_SB),
        .EXcontrole      (EXcontrole),
        .EXconstante     (EXconstante),
        .controleMuxResu (controleMuxResu),
        .controlePCcopia (controlePCcopia),
        .ula_op          (ula_op),
        .pc_escreve      (pc_escreve),
        .pc_sel          (pc_sel),
        .halted          (halted),
        .erro            (erro)
    );

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; a_zero = 1'b0; instr = 16'd0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    // Presents an instruction with an immediate ack; returns at the DECODE-cycle negedge.
    task automatic fetch(input logic [15:0] v);
        instr = v;
        imem_ack = 1'b1;
        @(negedge clock);
        imem_ack = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        #1;
        n_checks++;
        if ({imem_req, dmem_req, dmem_we, BR_Hab_Escrita, BR_Sel_E_SA, BR_Sel_SB, EXcontrole, EXconstante,
             controleMuxResu, controlePCcopia, ula_op, pc_escreve, pc_sel, halted, erro} !== 35'd0) begin
            n_fail++; $display("FAIL reset_outputs: got imem_req=%0b pc_escreve=%0b erro=%0b const=%h, want all 0",
                               imem_req, pc_escreve, erro, EXconstante);
        end
        @(negedge clock);
        reset = 1'b1;
        #1;
        n_checks++;
        if (imem_req !== 1'b0) begin
            n_fail++; $display("FAIL reset_release_req: got %0b want 0", imem_req);
        end
        @(negedge clock);
        n_checks++;
        if ({imem_req, EXconstante} !== {1'b1, 12'h000}) begin
            n_fail++; $display("FAIL reset_fetch_req: got req=%0b const=%h want req=1 const=000", imem_req, EXconstante);
        end
    endtask

    task automatic test_alu();
        fetch(16'h1A42);
        n_checks++;
        if ({BR_Sel_E_SA, BR_Sel_SB, imem_req} !== {3'd5, 3'd1, 1'b0}) begin
            n_fail++; $display("FAIL alu_decode_sel: got A=%0d B=%0d req=%0b want 5 1 0", BR_Sel_E_SA, BR_Sel_SB, imem_req);
        end
        @(negedge clock);
        n_checks++;
        if ({ula_op, BR_Hab_Escrita, pc_escreve} !== {3'd2, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL alu_exec: got ula_op=%0d we=%0b pc=%0b want 2 0 0", ula_op, BR_Hab_Escrita, pc_escreve);
        end
        @(negedge clock);
        n_checks++;
        if ({BR_Hab_Escrita, controleMuxResu, pc_escreve, pc_sel, BR_Sel_E_SA} !== {1'b1, 2'd0, 1'b1, 1'b0, 3'd5}) begin
            n_fail++; $display("FAIL alu_wb: got we=%0b mux=%0d pc=%0b sel=%0b A=%0d want 1 0 1 0 5",
                               BR_Hab_Escrita, controleMuxResu, pc_escreve, pc_sel, BR_Sel_E_SA);
        end
        @(negedge clock);
        n_checks++;
        if ({imem_req, BR_Hab_Escrita} !== 2'b10) begin
            n_fail++; $display("FAIL alu_latency: got req=%0b we=%0b want 1 0", imem_req, BR_Hab_Escrita);
        end
    endtask

    task automatic test_load();
        int req_cycles = 0;
        fetch(16'h3640);
        n_checks++;
        if ({BR_Sel_E_SA, BR_Sel_SB} !== {3'd3, 3'd1}) begin
            n_fail++; $display("FAIL load_decode_sel: got A=%0d B=%0d want 3 1", BR_Sel_E_SA, BR_Sel_SB);
        end
        @(negedge clock);
        @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            if (dmem_req === 1'b1 && dmem_we === 1'b0) req_cycles++;
            dmem_ack = (i == 3);
            @(negedge clock);
        end
        dmem_ack = 1'b0;
        n_checks++;
        if (req_cycles !== 4) begin
            n_fail++; $display("FAIL load_req_held: got %0d read-request cycles want 4", req_cycles);
        end
        n_checks++;
        if ({dmem_req, BR_Hab_Escrita, controleMuxResu, BR_Sel_E_SA, pc_escreve, pc_sel} !== {1'b0, 1'b1, 2'd1, 3'd3, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL load_wb: got req=%0b we=%0b mux=%0d A=%0d pc=%0b sel=%0b want 0 1 1 3 1 0",
                               dmem_req, BR_Hab_Escrita, controleMuxResu, BR_Sel_E_SA, pc_escreve, pc_sel);
        end
        @(negedge clock);
        n_checks++;
        if (imem_req !== 1'b1) begin
            n_fail++; $display("FAIL load_back_to_fetch: got %0b want 1", imem_req);
        end
    endtask

    task automatic test_store();
        fetch(16'h4A80);
        @(negedge clock);
        @(negedge clock);
        dmem_ack = 1'b1;
        #1;
        n_checks++;
        if ({dmem_req, dmem_we, pc_escreve, pc_sel, BR_Hab_Escrita} !== 5'b11100) begin
            n_fail++; $display("FAIL store_mem: got req=%0b we=%0b pc=%0b sel=%0b rwe=%0b want 1 1 1 0 0",
                               dmem_req, dmem_we, pc_escreve, pc_sel, BR_Hab_Escrita);
        end
        @(negedge clock);
        dmem_ack = 1'b0;
        n_checks++;
        if ({imem_req, dmem_req, BR_Hab_Escrita} !== 3'b100) begin
            n_fail++; $display("FAIL store_latency: got req=%0b dreq=%0b we=%0b want 1 0 0", imem_req, dmem_req, BR_Hab_Escrita);
        end
    endtask

    task automatic test_beqz(input logic az);
        fetch(16'h7005);
        n_checks++;
        if ({EXcontrole, EXconstante} !== {3'd1, 12'h005}) begin
            n_fail++; $display("FAIL beqz_decode_ext: got mode=%0d const=%h want 1 005", EXcontrole, EXconstante);
        end
        a_zero = az;
        @(negedge clock);
        n_checks++;
        if ({pc_escreve, pc_sel, BR_Hab_Escrita} !== {1'b1, az, 1'b0}) begin
            n_fail++; $display("FAIL beqz_exec_az%0b: got pc=%0b sel=%0b we=%0b want 1 %0b 0", az, pc_escreve, pc_sel, BR_Hab_Escrita, az);
        end
        @(negedge clock);
        a_zero = 1'b0;
        n_checks++;
        if ({imem_req, BR_Hab_Escrita, pc_escreve} !== 3'b100) begin
            n_fail++; $display("FAIL beqz_latency_az%0b: got req=%0b we=%0b pc=%0b want 1 0 0", az, imem_req, BR_Hab_Escrita, pc_escreve);
        end
    endtask

    task automatic test_jump();
        fetch(16'h5FFF);
        @(negedge clock);
        n_checks++;
        if ({EXcontrole, EXconstante, pc_escreve, pc_sel} !== {3'd2, 12'hFFF, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL jump_exec: got mode=%0d const=%h pc=%0b sel=%0b want 2 fff 1 1",
                               EXcontrole, EXconstante, pc_escreve, pc_sel);
        end
        @(negedge clock);
        n_checks++;
        if (imem_req !== 1'b1) begin
            n_fail++; $display("FAIL jump_latency: got req=%0b want 1", imem_req);
        end
    endtask

    task automatic test_nop_wait();
        int held = 0;
        for (int i = 0; i < 3; i++) begin
            if (imem_req === 1'b1) held++;
            @(negedge clock);
        end
        n_checks++;
        if (held !== 3) begin
            n_fail++; $display("FAIL fetch_req_held: got %0d cycles want 3", held);
        end
        fetch(16'h0000);
        @(negedge clock);
        n_checks++;
        if ({pc_escreve, pc_sel, BR_Hab_Escrita} !== 3'b100) begin
            n_fail++; $display("FAIL nop_exec: got pc=%0b sel=%0b we=%0b want 1 0 0", pc_escreve, pc_sel, BR_Hab_Escrita);
        end
        @(negedge clock);
    endtask

    task automatic test_jal();
        fetch(16'h6010);
        n_checks++;
        if ({EXcontrole, EXconstante, controlePCcopia} !== {3'd2, 12'h010, 1'b0}) begin
            n_fail++; $display("FAIL jal_decode: got mode=%0d const=%h copy=%0b want 2 010 0", EXcontrole, EXconstante, controlePCcopia);
        end
        @(negedge clock);
        n_checks++;
        if ({controlePCcopia, pc_escreve, BR_Hab_Escrita} !== 3'b100) begin
            n_fail++; $display("FAIL jal_exec: got copy=%0b pc=%0b we=%0b want 1 0 0", controlePCcopia, pc_escreve, BR_Hab_Escrita);
        end
        @(negedge clock);
        n_checks++;
        if ({BR_Hab_Escrita, BR_Sel_E_SA, controleMuxResu, pc_escreve, pc_sel, controlePCcopia} !== {1'b1, 3'd7, 2'd2, 1'b1, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL jal_wb: got we=%0b A=%0d mux=%0d pc=%0b sel=%0b copy=%0b want 1 7 2 1 1 0",
                               BR_Hab_Escrita, BR_Sel_E_SA, controleMuxResu, pc_escreve, pc_sel, controlePCcopia);
        end
        @(negedge clock);
        n_checks++;
        if (imem_req !== 1'b1) begin
            n_fail++; $display("FAIL jal_latency: got req=%0b want 1", imem_req);
        end
    endtask

    task automatic test_absorbing(input logic [15:0] v, input logic want_halt);
        int bad = 0;
        fetch(v);
        @(negedge clock);
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if ({halted, erro, imem_req, dmem_req, pc_escreve, BR_Hab_Escrita} !== {want_halt, ~want_halt, 4'b0000}) bad++;
            @(negedge clock);
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        n_checks++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL absorbing_%h: %0d bad cycles, last halted=%0b erro=%0b req=%0b pc=%0b want halted=%0b erro=%0b",
                               v, bad, halted, erro, imem_req, pc_escreve, want_halt, ~want_halt);
        end
        apply_reset();
        n_checks++;
        if ({halted, erro, imem_req} !== 3'b001) begin
            n_fail++; $display("FAIL absorbing_exit_%h: got halted=%0b erro=%0b req=%0b want 0 0 1", v, halted, erro, imem_req);
        end
    endtask

    task automatic test_reset_mem();
        fetch(16'h3640);
        @(negedge clock);
        @(negedge clock);
        n_checks++;
        if (dmem_req !== 1'b1) begin
            n_fail++; $display("FAIL rstmem_in_mem: got dreq=%0b want 1", dmem_req);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({dmem_req, imem_req} !== 2'b00) begin
            n_fail++; $display("FAIL rstmem_async_drop: got dreq=%0b ireq=%0b want 0 0", dmem_req, imem_req);
        end
        dmem_ack = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        dmem_ack = 1'b0;
        n_checks++;
        if ({imem_req, dmem_req, EXconstante, BR_Hab_Escrita} !== {1'b1, 1'b0, 12'h000, 1'b0}) begin
            n_fail++; $display("FAIL rstmem_after: got ireq=%0b dreq=%0b const=%h we=%0b want 1 0 000 0",
                               imem_req, dmem_req, EXconstante, BR_Hab_Escrita);
        end
    endtask

`ifdef UC_MEM_TIMEOUT_EN
    task automatic test_timeout();
        int cycles = 0;
        fetch(16'h3640);
        @(negedge clock);
        @(negedge clock);
        while (dmem_req === 1'b1 && cycles < 400) begin
            cycles++;
            @(negedge clock);
        end
        n_checks++;
        if ({erro, cycles} !== {1'b1, 32'd255}) begin
            n_fail++; $display("FAIL mem_timeout: got erro=%0b after %0d cycles want erro=1 after 255", erro, cycles);
        end
        apply_reset();
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_beqz(1'b1);
        test_beqz(1'b0);
        test_jump();
        test_nop_wait();
        test_jal();
        test_absorbing(16'hF000, 1'b0);
        test_absorbing(16'h8000, 1'b1);
        test_reset_mem();
`ifdef UC_MEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/unidade_controle.md
# unidade_controle

Multicycle control unit for the 16-bit processor. Fetches each instruction over a request/acknowledge handshake and latches it in an internal instruction register. It then sequences the decode/register-fetch stage through DECODE, EXEC, MEM and WB states by driving its register-bank, extender, result-mux and PC-copy selects. It also owns the PC update and data-memory handshakes and sits between the instruction/data memories and the ID_RF datapath.

## Interface
- TIMEOUT_CICLOS, 255: memory-wait limit in cycles (used only with UC_MEM_TIMEOUT_EN).
- R_LINK, 3'd7: register written by JAL.
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_ack  in  1  instruction valid on instr this cycle.
- instr  in  16  instruction word.
- dmem_ack  in  1  data access complete.
- a_zero  in  1  operand A equals zero (from datapath).
- imem_req  out  1  instruction fetch request.
- dmem_req, dmem_we  out  1,1  data access request, write enable.
- BR_Hab_Escrita  out  1  register-bank write enable.
- BR_Sel_E_SA, BR_Sel_SB  out  3,3  write/A-read select, B-read select.
- EXcontrole  out  3  extender mode (0 none, 1 sext9, 2 sext12).
- EXconstante  out  12  IR[11:0].
- controleMuxResu  out  2  0 ULA, 1 MD, 2 copied PC.
- controlePCcopia  out  1  load PC-copy register.
- ula_op  out  3  ALU function.
- pc_escreve, pc_sel  out  1,1  PC load; 0 = PC+1, 1 = PC+constant.
- halted, erro  out  1,1  stopped by HALT; illegal opcode or timeout.

## Operation
- Format: opcode IR[15:12], rA IR[11:9], rB IR[8:6], func IR[2:0].
- Opcodes: 0 NOP; 1 ALU rA<=rA op rB (ula_op=func); 2 LDI rA<=sext9; 3 LOAD rA<=MEM[rB]; 4 STORE MEM[rB]<=rA; 5 JUMP PC+=sext12; 6 JAL R_LINK<=PC+1, PC+=sext12; 7 BEQZ if a_zero PC+=sext9; 8 HALT; 9–15 illegal.
- States: FETCH → DECODE → EXEC → (MEM → WB | WB | FETCH). Also HALT and ERRO.
- FETCH: hold imem_req=1 until imem_ack. On ack, latch IR and go to DECODE.
- DECODE: drive BR_Sel_E_SA=rA, BR_Sel_SB=rB and EXcontrole. Illegal opcode → ERRO. HALT opcode → HALT.
- EXEC: ALU/LDI → WB. LOAD/STORE → MEM. JUMP/BEQZ pulse pc_escreve with pc_sel per rule, then → FETCH. JAL pulses controlePCcopia, then → WB. NOP pulses pc_escreve (pc_sel=0), then → FETCH.
- MEM: hold dmem_req until dmem_ack. dmem_we=1 for STORE only. LOAD → WB. STORE pulses pc_escreve (PC+1), then → FETCH.
- WB: BR_Hab_Escrita=1 for exactly one cycle. Mux: ULA for ALU/LDI, MD for LOAD, PC for JAL. JAL writes R_LINK and pulses pc_escreve with pc_sel=1. Other opcodes pulse pc_escreve with pc_sel=0. Then → FETCH.
- HALT and ERRO are absorbing; only reset leaves them.
- Selects remain stable from DECODE through WB of the same instruction.

## Timing
- Reset: state FETCH; IR=0. All outputs 0 except imem_req, which is 1 in FETCH one cycle after reset release.
- Reset mid-access drops req immediately (asynchronous). Late acks are ignored.
- Latency with ack in the first cycle: ALU/LDI 4 cycles; LOAD 5; STORE 4; JUMP/BEQZ/NOP 3; JAL 4.
- Exactly one pc_escreve pulse per instruction. None in HALT or ERRO.
- An ack arriving while req=0 is ignored.

## Configuration
- UC_MEM_TIMEOUT_EN: an 8-bit counter runs in FETCH and MEM while the request is pending. After TIMEOUT_CICLOS cycles without ack: drop req, set erro, enter ERRO.
- Without UC_MEM_TIMEOUT_EN: wait indefinitely; erro flags only illegal opcodes.

## Structure
- Package uc_pkg: opcode enum, state enum, mux-select constants (MUX_ULA/MUX_MD/MUX_PC) and extender modes.
- Sub-module uc_decodificador: combinational IR → instruction class, ula_op and extender mode. The FSM lives in unidade_controle.

## Test plan
- ALU instr 16'h1A42 (rA=5, rB=1, func=2), immediate ack → DECODE selects 5/1; BR_Hab_Escrita one cycle, mux=0, 4 cycles total.
- LOAD 16'h3640 with dmem_ack delayed 3 cycles → dmem_req held 4 cycles, dmem_we=0, write mux=1 to r3.
- BEQZ 16'h7005 with a_zero=1 then a_zero=0 → pc_sel=1 vs 0, no register write.
- JAL 16'h6010 → controlePCcopia pulse in EXEC; WB writes r7 with mux=2 and pc_sel=1.
- Opcode 16'hF000 → erro=1, ERRO state. HALT 16'h8000 → halted=1, imem_req=0 thereafter.
- reset asserted during MEM wait → dmem_req=0 asynchronously; after release, FETCH with IR=0. With UC_MEM_TIMEOUT_EN and no ack for 255 cycles → erro=1.
